// File: rtl/apb_master_cmdq.sv
// apb_master_cmdq: APB4 master behind a command FIFO.
// Commands arrive on a valid/ready stream and are queued. They are run one at a time
// as IDLE -> SETUP -> ACCESS transfers. Each transfer returns one response through a
// single-entry response register, with read data and an OK, PSLVERR or TIMEOUT status.
// DATA_W must be 8, 16 or 32. CMD_DEPTH must be a power of two, >= 2.
module apb_master_cmdq #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                pclk,
  input  logic                presetn,
  // command stream
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  // response stream
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic                busy,
  // APB4 master port
  output logic [ADDR_W-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(CMD_DEPTH);
  localparam int PTR_W  = IDX_W + 1;

  // The timeout counter holds 0..TIMEOUT_CYC-1. It keeps one bit when timeouts are disabled.
  localparam bit TMO_EN = (TIMEOUT_CYC != 0);
  localparam int TMO_W  = TMO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(TIMEOUT_CYC - 1) : '0;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_SLV = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // The pointers carry one extra wrap bit. Full and empty are therefore told apart
  // without a separate occupancy counter.
  // ---------------------------------------------------------------------------
  cmd_t             mem [CMD_DEPTH];
  cmd_t             cmd_in;
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;

  assign cmd_in     = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strb: cmd_strb};
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem[rd_ptr[IDX_W-1:0]];

  // Write the accepted command into the slot selected by the write pointer.
  // NOTE: the storage array has no reset. The pointers alone decide which entries are
  // valid. Leaving reset off also lets the array map onto plain RAM.
  always_ff @(posedge pclk) begin
    if (push) begin
      mem[wr_ptr[IDX_W-1:0]] <= cmd_in;
    end
  end

  // Advance the FIFO pointers. Reset empties the queue.
  // NOTE: sequential state is always updated with <=, so every flop samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  cmd_t             cur;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             rsp_free;

  // The response register can take a new result once it is empty or being drained this cycle.
  assign rsp_free = !rsp_valid || rsp_ready;
  // The timeout fires on the TIMEOUT_CYC-th ACCESS cycle. pready takes priority on that cycle.
  assign tmo_hit  = TMO_EN && (tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the FIFO pop request.
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && rsp_free) begin
          pop       = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (pready || tmo_hit) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Capture the popped command. Reads carry zero write data and strobes onto the bus.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      cur <= '0;
    end else if (pop) begin
      cur.write <= head.write;
      cur.addr  <= head.addr;
      cur.wdata <= head.write ? head.wdata : '0;
      cur.strb  <= head.write ? head.strb  : '0;
    end
  end

  // Count ACCESS cycles of the current transfer. The count restarts in SETUP.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      tmo_cnt <= '0;
    end else if (state == S_SETUP) begin
      tmo_cnt <= '0;
    end else if (state == S_ACCESS) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Load the response when a transfer ends, and release it on the response handshake.
  // A new transfer starts only once this register is free. A load and a drain therefore
  // never fall on the same cycle.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
    end else if (state == S_ACCESS && pready) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= cur.write ? '0 : prdata;
      rsp_err   <= pslverr ? ERR_SLV : ERR_OK;
    end else if (state == S_ACCESS && tmo_hit) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= '0;
      rsp_err   <= ERR_TMO;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Drive the APB bus from the captured command. All bus outputs are zero in IDLE.
  always_comb begin
    psel    = 1'b0;
    penable = 1'b0;
    paddr   = '0;
    pwrite  = 1'b0;
    pwdata  = '0;
    pstrb   = '0;
    if (state != S_IDLE) begin
      psel    = 1'b1;
      penable = (state == S_ACCESS);
      paddr   = cur.addr;
      pwrite  = cur.write;
      pwdata  = cur.wdata;
      pstrb   = cur.strb;
    end
  end

  assign busy = !fifo_empty || (state != S_IDLE) || rsp_valid;

endmodule

// File: tb/tb_apb_master_cmdq.sv
// tb_apb_master_cmdq: randomized bench for apb_master_cmdq.
// The reference model tracks the command queue, the FIFO occupancy, and the planned behaviour
// of the slave for each transfer: wait states, error, read data and timeout. From these it
// predicts the bus fields, the transfer length, the handshakes and every response.
module tb_apb_master_cmdq;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 4;
  localparam int TMO    = 16;

  logic              pclk = 1'b0;
  logic              presetn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;
  logic              busy;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  apb_master_cmdq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic [1:0]        err;
  } rsp_t;

  cmd_t cmd_q[$];   // accepted commands not yet seen on the bus
  rsp_t rsp_q[$];   // expected responses, in issue order

  int   n_checks = 0;
  int   n_pass   = 0;

  int   fifo_cnt;
  bit   rsp_avail;
  bit   prev_idle, prev_setup, prev_access, prev_pready, exp_setup_next;
  int   acc_n;
  int   waits;
  logic plan_err;
  logic [DATA_W-1:0] plan_rdata;
  cmd_t cur;
  int   p_cmd, p_rdy, p_stuck;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One clock cycle. Outputs are sampled at the falling edge, the model is checked and
  // advanced, and inputs are driven for the next rising edge.
  task automatic step();
    bit                idle, setup, access, ended;
    rsp_t              r;
    cmd_t              c;
    logic [DATA_W-1:0] exp_wdata;
    logic [STRB_W-1:0] exp_strb;
    @(negedge pclk);
    idle   = !psel;
    setup  = psel && !penable;
    access = psel && penable;
    check("penable_without_psel", penable && !psel, 1'b0);

    if (prev_idle)  check("setup_start", setup, exp_setup_next);
    if (prev_setup) check("setup_to_access", access, 1'b1);
    if (prev_access) begin
      ended = prev_pready || (acc_n == TMO);
      check("access_end", {idle, access}, ended ? 2'b10 : 2'b01);
      if (ended) rsp_avail = 1'b1;
    end

    if (idle) begin
      check("idle_paddr", paddr, '0);
      check("idle_wdata_ctl", {pwrite, pstrb, pwdata}, '0);
    end

    if (setup) begin
      fifo_cnt--;
      check("no_start_with_rsp_pending", rsp_q.size(), 0);
      check("setup_cmd_available", cmd_q.size() != 0, 1'b1);
      if (cmd_q.size() != 0) begin
        cur = cmd_q.pop_front();
        if ($urandom_range(0, 99) < p_stuck) waits = 1000;
        else begin
          case ($urandom_range(0, 7))
            0, 1, 2: waits = 0;
            3:       waits = 1;
            4:       waits = 2;
            5:       waits = 3;
            6:       waits = TMO - 1;
            default: waits = TMO - 2;
          endcase
        end
        plan_err   = ($urandom_range(0, 3) == 0);
        plan_rdata = $urandom;
        if (waits < TMO) begin
          r.rdata = cur.wr ? '0 : plan_rdata;
          r.err   = plan_err ? 2'b01 : 2'b00;
        end else begin
          r.rdata = '0;
          r.err   = 2'b10;
        end
        rsp_q.push_back(r);
      end
      acc_n = 0;
    end

    if (setup || access) begin
      exp_wdata = cur.wr ? cur.wdata : '0;
      exp_strb  = cur.wr ? cur.strb  : '0;
      check("paddr", paddr, cur.addr);
      check("pwrite_pstrb", {pwrite, pstrb}, {cur.wr, exp_strb});
      check("pwdata", pwdata, exp_wdata);
    end

    // Slave: pready comes after 'waits' wait states. Other signals are noise when not ready.
    if (access) begin
      acc_n++;
      pready = (acc_n > waits);
      if (pready) begin
        prdata  = plan_rdata;
        pslverr = plan_err;
      end else begin
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
    end else begin
      pready  = 1'($urandom);
      prdata  = $urandom;
      pslverr = 1'($urandom);
    end
    prev_pready = access && pready;

    check("cmd_ready", cmd_ready, fifo_cnt < DEPTH);
    check("busy", busy, (fifo_cnt != 0) || (rsp_q.size() != 0));
    check("rsp_valid", rsp_valid, rsp_avail);

    rsp_ready      = ($urandom_range(0, 99) < p_rdy);
    exp_setup_next = idle && (fifo_cnt > 0) && (!rsp_avail || rsp_ready);
    if (rsp_valid && rsp_ready) begin
      check("rsp_expected", rsp_q.size() != 0, 1'b1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        check("rsp_rdata", rsp_rdata, r.rdata);
        check("rsp_err", rsp_err, r.err);
      end
      rsp_avail = 1'b0;
    end

    cmd_valid = ($urandom_range(0, 99) < p_cmd);
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom & 32'hFFFF_FFFC;
    cmd_wdata = $urandom;
    cmd_strb  = STRB_W'($urandom);
    if (cmd_valid && cmd_ready) begin
      c.wr    = cmd_write;
      c.addr  = cmd_addr;
      c.wdata = cmd_wdata;
      c.strb  = cmd_strb;
      cmd_q.push_back(c);
      fifo_cnt++;
    end

    prev_idle   = idle;
    prev_setup  = setup;
    prev_access = access;
  endtask

  // Hold reset for a number of cycles, check the quiet state, then release and clear the model.
  task automatic apply_reset(input int cycles);
    presetn   = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;
    repeat (cycles) begin
      @(negedge pclk);
      check("rst_psel_penable", {psel, penable}, 2'b00);
      check("rst_rsp_valid_err", {rsp_valid, rsp_err}, 3'b000);
      check("rst_rsp_rdata", rsp_rdata, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_paddr", paddr, '0);
    end
    presetn = 1'b1;
    check("cmd_ready_after_reset", cmd_ready, 1'b1);
    cmd_q.delete();
    rsp_q.delete();
    fifo_cnt       = 0;
    rsp_avail      = 1'b0;
    prev_idle      = 1'b1;
    prev_setup     = 1'b0;
    prev_access    = 1'b0;
    prev_pready    = 1'b0;
    exp_setup_next = 1'b0;
    acc_n          = 0;
  endtask

  initial begin
    int guard;
    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    p_cmd     = 0;
    p_rdy     = 0;
    p_stuck   = 0;
    apply_reset(2);

    // Sparse traffic with an always-ready consumer.
    p_cmd = 30; p_rdy = 100; p_stuck = 0;
    repeat (300) step();

    // Response back-pressure: one transfer completes, then the FIFO fills up.
    p_cmd = 100; p_rdy = 0;
    repeat (40) step();
    check("fifo_full_under_backpressure", cmd_ready, 1'b0);
    p_cmd = 0; p_rdy = 100;
    repeat (150) step();

    // Mixed traffic with errors, wait states and timeouts.
    p_cmd = 50; p_rdy = 60; p_stuck = 10;
    repeat (2500) step();

    // Reset in the middle of a stalled ACCESS phase.
    p_cmd = 100; p_rdy = 100; p_stuck = 100;
    guard = 0;
    while (!(prev_access && acc_n >= 3) && guard < 300) begin
      step();
      guard++;
    end
    check("reached_access_for_reset", prev_access && acc_n >= 3, 1'b1);
    apply_reset(2);

    p_cmd = 40; p_rdy = 70; p_stuck = 5;
    repeat (800) step();

    // Drain everything.
    p_cmd = 0; p_rdy = 100; p_stuck = 0;
    repeat (300) step();
    check("drained_busy", busy, 1'b0);
    check("all_rsp_returned", rsp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
